// File: rtl/lab2_proc_imul_arbiter_if.sv
// Bundle of the requester-side and multiplier-side val/rdy channels used by
// the round-robin multiplier arbiter. The arbiter connects through the slave
// modport; the surrounding requesters plus the multiplier use master.
interface lab2_proc_imul_arbiter_if #(
  parameter int p_num_reqs = 2
);
  // requester request channel
  logic [p_num_reqs-1:0]    req_val;
  logic [p_num_reqs-1:0]    req_rdy;
  logic [64*p_num_reqs-1:0] req_msg;

  // requester response channel
  logic [p_num_reqs-1:0]    resp_val;
  logic [p_num_reqs-1:0]    resp_rdy;
  logic [31:0]              resp_msg;

  // multiplier istream
  logic                     mul_req_val;
  logic                     mul_req_rdy;
  logic [63:0]              mul_req_msg;

  // multiplier ostream
  logic                     mul_resp_val;
  logic                     mul_resp_rdy;
  logic [31:0]              mul_resp_msg;

  modport slave (
    input  req_val, req_msg, resp_rdy,
    input  mul_req_rdy, mul_resp_val, mul_resp_msg,
    output req_rdy, resp_val, resp_msg,
    output mul_req_val, mul_req_msg, mul_resp_rdy
  );

  modport master (
    output req_val, req_msg, resp_rdy,
    output mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  req_rdy, resp_val, resp_msg,
    input  mul_req_val, mul_req_msg, mul_resp_rdy
  );
endinterface

// File: rtl/lab2_proc_imul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_num_reqs
// requesters. One operation is in flight at a time; the owner index steers
// the product back to the requester that issued it.
// Optional feature macro: IMUL_ARB_B2B_EN -- when defined, the cycle that
// completes a response may also issue the next granted request, removing
// the idle cycle between back-to-back operations.
module lab2_proc_imul_arbiter #(
  parameter int p_num_reqs = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  lab2_proc_imul_arbiter_if.slave       io,
  output logic                          busy,
  output logic [$clog2(p_num_reqs)-1:0] owner
);

  // derived width of the requester index
  localparam int p_owner_nbits = $clog2(p_num_reqs);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]               state;
  logic [0:0]               state_next;
  logic [p_owner_nbits-1:0] ptr;
  logic [p_owner_nbits-1:0] ptr_next;
  logic [p_owner_nbits-1:0] owner_next;
  logic [p_owner_nbits-1:0] grant;

  logic any_req;
  logic found;
  logic issue_window;
  logic issue;
  logic resp_hs;

  logic [63:0] slice [p_num_reqs];

  assign any_req = |io.req_val;

  // Response handshake of the in-flight operation with its owner.
  assign resp_hs = (state == WAIT) && io.mul_resp_val && io.resp_rdy[owner];

  // Cycles in which a new operation may be presented to the multiplier.
`ifdef IMUL_ARB_B2B_EN
  assign issue_window = (state == IDLE) || resp_hs;
`else
  assign issue_window = (state == IDLE);
`endif

  // Round-robin search: first active requester starting at ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    grant = ptr;
    found = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = int'(ptr) + k;
      if (idx >= p_num_reqs) begin
        idx = idx - p_num_reqs;
      end
      if (!found && io.req_val[idx]) begin
        grant = p_owner_nbits'(idx);
        found = 1'b1;
      end
    end
  end

  // Per-requester operand slices and one-hot ready/valid steering.
  generate
    for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_req
      assign slice[gi] = io.req_msg[gi*64 +: 64];

      assign io.req_rdy[gi] = issue_window && io.req_val[gi] && io.mul_req_rdy
                              && (grant == p_owner_nbits'(gi));

      assign io.resp_val[gi] = (state == WAIT) && io.mul_resp_val
                               && (owner == p_owner_nbits'(gi));
    end
  endgenerate

  assign io.mul_req_val  = issue_window && any_req;
  assign io.mul_req_msg  = io.mul_req_val ? slice[grant] : 64'd0;
  assign issue           = io.mul_req_val && io.mul_req_rdy;

  // A product arriving while IDLE is a protocol error and is neither
  // acknowledged nor forwarded; only the owner's ready is passed through.
  assign io.mul_resp_rdy = (state == WAIT) && io.resp_rdy[owner];
  assign io.resp_msg     = (state == WAIT) ? io.mul_resp_msg : 32'd0;

  assign busy = (state == WAIT);

  // Next-state logic for the FSM, priority pointer and owner index.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;

    case (state)
      IDLE: begin
        if (issue) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // a same-cycle issue only happens when back-to-back is enabled
        if (resp_hs) begin
          state_next = issue ? WAIT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (issue) begin
      owner_next = grant;
      ptr_next   = (grant == p_owner_nbits'(p_num_reqs - 1)) ? '0 : grant + 1'b1;
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

endmodule

// File: doc/lab2_proc_imul_arbiter.md
# lab2_proc_imul_arbiter

Round-robin arbiter that shares the single iterative integer multiplier (`lab1_imul_IntMulAlt`) among `p_num_reqs` requesters, such as the X stages of several cores or lanes. It forwards one 64-bit operand message at a time to the multiplier and records which requester owns the in-flight operation. It then steers the 32-bit product back to that requester only. Only one operation is outstanding at a time. All handshakes are val/rdy, latency-insensitive.

## Interface
- `p_num_reqs`, 2, number of requesters; legal range 2..8.
- `p_owner_nbits`, `$clog2(p_num_reqs)`, width of the owner index; derived, never overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `req_val`  in  p_num_reqs  per-requester request valid.
- `req_rdy`  out  p_num_reqs  per-requester request ready.
- `req_msg`  in  64*p_num_reqs  flattened operands; slice i = `{op2, op1}` of requester i.
- `resp_val`  out  p_num_reqs  per-requester response valid.
- `resp_rdy`  in  p_num_reqs  per-requester response ready.
- `resp_msg`  out  32  shared product bus; meaningful only where `resp_val` is set.
- `mul_req_val`  out  1  to multiplier `istream_val`.
- `mul_req_rdy`  in  1  from multiplier `istream_rdy`.
- `mul_req_msg`  out  64  to multiplier `istream_msg`.
- `mul_resp_val`  in  1  from multiplier `ostream_val`.
- `mul_resp_rdy`  out  1  to multiplier `ostream_rdy`.
- `mul_resp_msg`  in  32  from multiplier `ostream_msg`.
- `busy`  out  1  1 while in WAIT.
- `owner`  out  p_owner_nbits  registered index of the in-flight requester.

## Operation
- Registered state:
  - FSM with two states, IDLE and WAIT.
  - Priority pointer `ptr`, p_owner_nbits wide.
  - `owner`, p_owner_nbits wide.
- Grant: combinational round-robin. `grant` is the first i with `req_val[i]`=1, searching `ptr`, `ptr+1`, … modulo p_num_reqs.
- IDLE:
  - `mul_req_val` = OR of `req_val`; `mul_req_msg` = slice `grant`.
  - `req_rdy[grant]` = `mul_req_rdy`; all other `req_rdy` = 0.
  - `resp_val` = 0, `mul_resp_rdy` = 0.
- IDLE issue (`mul_req_val && mul_req_rdy`):
  - `owner` <= `grant`.
  - `ptr` <= `grant+1`, wrapping p_num_reqs-1 → 0.
  - Next state WAIT.
- WAIT:
  - `mul_req_val` = 0 and all `req_rdy` = 0, unless `IMUL_ARB_B2B_EN` is defined (see Configuration).
  - `resp_val[owner]` = `mul_resp_val`; all other `resp_val` = 0.
  - `mul_resp_rdy` = `resp_rdy[owner]`; `resp_msg` = `mul_resp_msg`.
- WAIT response (`mul_resp_val && resp_rdy[owner]`): next state IDLE.
- `resp_msg` passes through unmodified; the arbiter performs no arithmetic.
- Requests not granted are held by their senders. `req_msg` of an ungranted requester is ignored.
- `mul_resp_val` asserted in IDLE is a protocol error. It is not acknowledged (`mul_resp_rdy`=0) and no `resp_val` is raised.

## Timing
- Reset values: state IDLE, `ptr`=0, `owner`=0, `busy`=0.
- With all `req_val`=0, every output is 0.
- Request path is combinational. Issue takes 0 added cycles: the `req_rdy` handshake and the multiplier handshake occur in the same cycle.
- Response path is combinational. The product reaches `resp_msg` in the same cycle `mul_resp_val` rises.
- Minimum gap between successive issues:
  - Without the macro: 1 idle cycle after the response handshake.
  - With the macro: 0 idle cycles.
- Backpressure: while `resp_rdy[owner]`=0, the FSM stays in WAIT, `owner` is held and no new grant is issued.
- Simultaneous requests: exactly one grant per issue. `ptr` ensures every active requester is served within p_num_reqs issues.
- Reset mid-operation (`reset`=0 in WAIT): state returns immediately to IDLE and `ptr`/`owner` return to 0. The multiplier shares `reset`, so the in-flight product is discarded. No `resp_val` is produced for it.

## Configuration
- Macro: `IMUL_ARB_B2B_EN`.
- Defined: in WAIT, during the response-handshake cycle, the arbiter also presents the next `grant` to the multiplier.
  - `req_rdy[grant]` and `mul_req_val` follow the IDLE rules in that cycle.
  - If that issue handshakes, the next state is WAIT with the new `owner`; otherwise IDLE.
- Undefined: WAIT never issues, and exactly one IDLE cycle separates operations.

## Test plan
- Single request: requester 0 sends op1=7, op2=3 → one cycle with `mul_req_val`=1; then `resp_val[0]`=1 with `resp_msg`=21. `resp_val[1]` and `req_rdy[1]` stay 0 throughout.
- Simultaneous requests: after reset, requesters 0 and 1 both assert → requester 0 is served first (op1=2, op2=5 → 10), then requester 1 (op1=4, op2=4 → 16). `owner` reads 0 then 1.
- Response backpressure: `resp_rdy[1]`=0 for 5 cycles while 1 owns the multiplier → `mul_resp_rdy`=0, `busy`=1 and `owner`=1 held. `req_rdy[0]` stays 0 despite `req_val[0]`=1. The product is delivered on the cycle `resp_rdy[1]` rises.
- Fairness: requester 1 requests continuously; requester 0 asserts once mid-stream → requester 0 is granted on the next issue after the current one. The issue order is 1, 0, 1.
- Reset in WAIT: drive `reset`=0 two cycles after issue → `busy`=0, `owner`=0 and all `resp_val`=0 immediately. After `reset` returns to 1, a new request from requester 1 is granted first.
- Macro check: issue 4 back-to-back multiplies from requester 0 and count the cycles from each response handshake to the next issue → 0 with `IMUL_ARB_B2B_EN` defined, 1 without.
